// File: rtl/mst_fifo_pkg.sv
// Shared types for the FT600 master write path: the {be, data} prefetch word
// passed between the prefetch source, the master FSM and the data checker.
package mst_fifo_pkg;

    localparam int         PREF_W       = 36;
    localparam logic [3:0] PREF_BE_FULL = 4'hF;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } pref_word_t;

    function automatic pref_word_t pref_word(input logic [31:0] data);
        pref_word_t w;
        w.be   = PREF_BE_FULL;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/mst_pref_ram.sv
// Prefetch FIFO storage: DEPTH x 36 register array.
// Synchronous write port, asynchronous read port.
module mst_pref_ram
    import mst_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [PREF_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [PREF_W-1:0] rdata
);

    logic [PREF_W-1:0] mem [DEPTH];

    // Write the addressed entry on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mst_pref_gen.sv
// Prefetch source: incrementing 32-bit pattern buffered in a small FIFO.
// Optional error injection on the next pushed word: MST_PREF_ERR_INJECT_EN.
module mst_pref_gen
    import mst_fifo_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] SEED  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prefena,
    input  logic                   prefreq,
    input  logic                   gen_restart,
    input  logic                   err_inj,
    output logic [PREF_W-1:0]      prefdout,
    output logic                   pref_empty,
    output logic [$clog2(DEPTH):0] pref_level,
    output logic                   pref_uflow
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             LW       = AW + 1;
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]  LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [31:0]       gen_data;
    logic              uflow;
    logic              empty;
    logic              push;
    logic              pop;
    logic              we;
    logic              inj_bit;
    pref_word_t        wr_word;
    logic [PREF_W-1:0] rd_word;

    assign empty = (level == '0);
    assign pop   = prefreq & ~empty;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push  = (level < LVL_FULL) | pop;
    assign we    = push & ~gen_restart;

`ifdef MST_PREF_ERR_INJECT_EN
    logic inj_pend;

    // Pending flag: armed by err_inj, consumed by the next push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend <= 1'b0;
        end else if (gen_restart) begin
            inj_pend <= 1'b0;
        end else if (err_inj) begin
            inj_pend <= 1'b1;
        end else if (push) begin
            inj_pend <= 1'b0;
        end
    end

    assign inj_bit = inj_pend;
`else
    logic unused_inj;

    assign unused_inj = err_inj;
    assign inj_bit    = 1'b0;
`endif

    // Corruption touches only the stored copy; gen_data keeps counting exactly.
    assign wr_word = pref_word({gen_data[31:1], gen_data[0] ^ inj_bit});

    mst_pref_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Pointers, level, generator and sticky underflow; restart wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            gen_data <= SEED;
            uflow    <= 1'b0;
        end else if (gen_restart) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            gen_data <= SEED;
            uflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                gen_data <= gen_data + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (prefreq && empty && prefena) begin
                uflow <= 1'b1;
            end
        end
    end

    assign prefdout   = empty ? '0 : rd_word;
    assign pref_empty = empty;
    assign pref_level = level;
    assign pref_uflow = uflow;

endmodule

// File: tb/tb_mst_pref_gen.sv
// Self-checking bench for mst_pref_gen: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_mst_pref_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prefena;
    logic        prefreq;
    logic        gen_restart;
    logic        err_inj;
    logic [35:0] dout;
    logic        empty;
    logic [2:0]  lvl;
    logic        uf;
    logic [35:0] dout_w;
    logic        empty_w;
    logic [2:0]  lvl_w;
    logic        uf_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] mq[$];
    logic [31:0] mgen;
    logic        muf;
    logic        mpend;

    mst_pref_gen #(
        .DEPTH (DEPTH),
        .SEED  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prefena     (prefena),
        .prefreq     (prefreq),
        .gen_restart (gen_restart),
        .err_inj     (err_inj),
        .prefdout    (dout),
        .pref_empty  (empty),
        .pref_level  (lvl),
        .pref_uflow  (uf)
    );

    mst_pref_gen #(
        .DEPTH (DEPTH),
        .SEED  (32'hFFFF_FFFE)
    ) dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .prefena     (prefena),
        .prefreq     (prefreq),
        .gen_restart (gen_restart),
        .err_inj     (err_inj),
        .prefdout    (dout_w),
        .pref_empty  (empty_w),
        .pref_level  (lvl_w),
        .pref_uflow  (uf_w)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mgen  = 32'h0;
        muf   = 1'b0;
        mpend = 1'b0;
    endtask

    task automatic model_edge();
        bit do_pop;
        bit do_push;
        if (!rst_n || gen_restart) begin
            model_reset();
            return;
        end
        do_pop = prefreq && (mq.size() > 0);
        if (prefreq && (mq.size() == 0) && prefena) muf = 1'b1;
        do_push = (mq.size() < DEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
`ifdef MST_PREF_ERR_INJECT_EN
            mq.push_back({4'hF, mgen ^ {31'b0, mpend}});
            mpend = 1'b0;
`else
            mq.push_back({4'hF, mgen});
`endif
            mgen = mgen + 32'd1;
        end
`ifdef MST_PREF_ERR_INJECT_EN
        if (err_inj) mpend = 1'b1;
`endif
    endtask

    function automatic logic [35:0] mhead();
        return (mq.size() == 0) ? 36'h0 : mq[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        prefena     = 1'b0;
        prefreq     = 1'b0;
        gen_restart = 1'b0;
        err_inj     = 1'b0;
        model_reset();
        #22;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        prefena     = 1'b0;
        prefreq     = 1'b0;
        gen_restart = 1'b0;
        err_inj     = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if (dout !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_dout got %h exp %h", dout, 36'h0);
        end
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty got %b exp 1", empty);
        end
        n_tests++;
        if (lvl !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_level got %0d exp 0", lvl);
        end
        n_tests++;
        if (uf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_uflow got %b exp 0", uf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            logic [2:0] el;
            tick();
            el = (i < 4) ? 3'(i) : 3'd4;
            n_tests++;
            if (lvl !== el) begin
                n_fail++;
                $display("FAIL fill_level cyc %0d got %0d exp %0d", i, lvl, el);
            end
            n_tests++;
            if (dout !== 36'hF_0000_0000) begin
                n_fail++;
                $display("FAIL fill_dout cyc %0d got %h exp %h", i, dout, 36'hF_0000_0000);
            end
            n_tests++;
            if (empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_empty cyc %0d got %b exp 0", i, empty);
            end
        end
    endtask

    task automatic test_full_stream();
        prefena = 1'b1;
        prefreq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [35:0] ed;
            ed = {4'hF, 32'(i)};
            n_tests++;
            if (dout !== ed) begin
                n_fail++;
                $display("FAIL stream_dout word %0d got %h exp %h", i, dout, ed);
            end
            n_tests++;
            if (lvl !== 3'd4 || uf !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_flags word %0d got lvl=%0d uf=%b exp lvl=4 uf=0", i, lvl, uf);
            end
            tick();
        end
        prefreq = 1'b0;
        prefena = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [4];
        wexp[0] = 32'hFFFF_FFFE;
        wexp[1] = 32'hFFFF_FFFF;
        wexp[2] = 32'h0000_0000;
        wexp[3] = 32'h0000_0001;
        do_reset();
        repeat (4) tick();
        n_tests++;
        if (lvl_w !== 3'd4 || empty_w !== 1'b0 || uf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_full got lvl=%0d empty=%b uf=%b exp 4 0 0", lvl_w, empty_w, uf_w);
        end
        prefreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dout_w !== {4'hF, wexp[i]}) begin
                n_fail++;
                $display("FAIL wrap_dout word %0d got %h exp %h", i, dout_w, {4'hF, wexp[i]});
            end
            tick();
        end
        prefreq = 1'b0;
    endtask

    task automatic test_uflow();
        rst_n       = 1'b0;
        prefreq     = 1'b0;
        prefena     = 1'b0;
        gen_restart = 1'b0;
        err_inj     = 1'b0;
        model_reset();
        #22;
        @(negedge clk);
        rst_n   = 1'b1;
        prefreq = 1'b1;
        prefena = 1'b1;
        #1;
        n_tests++;
        if (dout !== 36'h0) begin
            n_fail++;
            $display("FAIL uflow_dout got %h exp %h", dout, 36'h0);
        end
        tick();
        prefreq = 1'b0;
        prefena = 1'b0;
        n_tests++;
        if (uf !== 1'b1) begin
            n_fail++;
            $display("FAIL uflow_set got %b exp 1", uf);
        end
        tick();
        n_tests++;
        if (uf !== 1'b1) begin
            n_fail++;
            $display("FAIL uflow_sticky got %b exp 1", uf);
        end
        gen_restart = 1'b1;
        tick();
        gen_restart = 1'b0;
        n_tests++;
        if (uf !== 1'b0 || lvl !== 3'd0) begin
            n_fail++;
            $display("FAIL uflow_clear got uf=%b lvl=%0d exp 0 0", uf, lvl);
        end
        prefreq = 1'b1;
        prefena = 1'b0;
        tick();
        prefreq = 1'b0;
        n_tests++;
        if (uf !== 1'b0) begin
            n_fail++;
            $display("FAIL uflow_gated got %b exp 0", uf);
        end
    endtask

    task automatic test_restart_burst();
        do_reset();
        repeat (5) tick();
        prefena = 1'b1;
        prefreq = 1'b1;
        tick();
        tick();
        gen_restart = 1'b1;
        tick();
        gen_restart = 1'b0;
        prefreq     = 1'b0;
        prefena     = 1'b0;
        n_tests++;
        if (lvl !== 3'd0 || empty !== 1'b1 || dout !== 36'h0) begin
            n_fail++;
            $display("FAIL restart_clear got lvl=%0d empty=%b dout=%h exp 0 1 0", lvl, empty, dout);
        end
        tick();
        n_tests++;
        if (dout !== 36'hF_0000_0000 || lvl !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_seed got dout=%h lvl=%0d exp %h 1", dout, lvl, 36'hF_0000_0000);
        end
    endtask

    task automatic test_err_inj();
        logic [31:0] iexp [7];
        iexp[0] = 32'd0;
        iexp[1] = 32'd1;
        iexp[2] = 32'd2;
        iexp[3] = 32'd3;
`ifdef MST_PREF_ERR_INJECT_EN
        iexp[4] = 32'd5;
`else
        iexp[4] = 32'd4;
`endif
        iexp[5] = 32'd5;
        iexp[6] = 32'd6;
        do_reset();
        repeat (5) tick();
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        tick();
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        tick();
        prefreq = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (dout !== {4'hF, iexp[i]}) begin
                n_fail++;
                $display("FAIL inj_dout word %0d got %h exp %h", i, dout, {4'hF, iexp[i]});
            end
            tick();
        end
        prefreq = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            prefreq     = ($urandom_range(0, 99) < 60);
            prefena     = ($urandom_range(0, 99) < 70);
            err_inj     = ($urandom_range(0, 99) < 5);
            gen_restart = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
            n_tests++;
            if (dout !== mhead()) begin
                n_fail++;
                $display("FAIL rand_dout cyc %0d got %h exp %h", c, dout, mhead());
            end
            n_tests++;
            if (lvl !== 3'(mq.size())) begin
                n_fail++;
                $display("FAIL rand_level cyc %0d got %0d exp %0d", c, lvl, mq.size());
            end
            n_tests++;
            if (empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_empty cyc %0d got %b exp %b", c, empty, mq.size() == 0);
            end
            n_tests++;
            if (uf !== muf) begin
                n_fail++;
                $display("FAIL rand_uflow cyc %0d got %b exp %b", c, uf, muf);
            end
        end
        prefreq     = 1'b0;
        prefena     = 1'b0;
        err_inj     = 1'b0;
        gen_restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_wrap();
        test_uflow();
        test_restart_burst();
        test_err_inj();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
